echo_delay_unit: RTL and testbench

// - Feedback echo stage between music_player sample output and adau1761_codec hphone_l input.
// - Keeps a circular delay line of past outputs in block RAM.
// - On each new sample: out = sat(in + (delayed >>> atten_shift)); out is also written back,
//   so each echo repeats and decays. Delay length, attenuation and enable change at run time.

---
 rtl/echo_delay_unit.sv | 214 +++++++++++++++++++++
 tb/tb_echo_delay_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_unit.sv
// ----------------------------------------------------------------------------
// echo_delay_unit
//
// Feedback echo stage that sits between the music player's sample output and
// the codec headphone input. Past output samples are kept in a circular delay
// line in block RAM. Each accepted input sample is mixed with an attenuated
// copy of the sample written `delay` positions earlier. The saturated result
// is written back, so every echo repeats and decays.
//
// Ports
//   clk_100           in   system clock (100 MHz)
//   reset             in   asynchronous, active-high reset
//   new_sample_ready  in   one-cycle pulse, in_sample valid in the same cycle
//   in_sample         in   dry input sample, signed
//   echo_enable       in   1 = mix echo, 0 = dry pass-through
//   delay_samples     in   echo delay in samples (0 is treated as 1)
//   atten_shift       in   echo gain = 2**-atten_shift
//   out_sample        out  registered output sample, signed
//   out_valid         out  one-cycle pulse when out_sample updates
//   clearing          out  high while the post-reset RAM clear runs
//   overrun           out  sticky flag: a pulse arrived while busy
// ----------------------------------------------------------------------------
module echo_delay_unit #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_BITS    = 15
) (
    input  logic                           clk_100,
    input  logic                           reset,
    input  logic                           new_sample_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
    input  logic                           echo_enable,
    input  logic        [ADDR_BITS-1:0]    delay_samples,
    input  logic        [2:0]              atten_shift,
    output logic signed [SAMPLE_WIDTH-1:0] out_sample,
    output logic                           out_valid,
    output logic                           clearing,
    output logic                           overrun
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_MIX   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_ZERO = {SAMPLE_WIDTH{1'b0}};

    // Clamp a (SAMPLE_WIDTH+1)-bit sum into the signed SAMPLE_WIDTH range.
    // The two top bits differ exactly when the sum left the narrow range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(
        input logic signed [SAMPLE_WIDTH:0] sum
    );
        logic signed [SAMPLE_WIDTH-1:0] res;
        if (sum[SAMPLE_WIDTH] != sum[SAMPLE_WIDTH-1]) begin
            res = sum[SAMPLE_WIDTH] ? SAMPLE_MIN : SAMPLE_MAX;
        end else begin
            res = sum[SAMPLE_WIDTH-1:0];
        end
        return res;
    endfunction

    // Registers
    logic        [2:0]              r_state;
    logic        [ADDR_BITS-1:0]    r_clr_addr;
    logic        [ADDR_BITS-1:0]    r_wr_ptr;
    logic        [ADDR_BITS-1:0]    r_rd_addr;
    logic signed [SAMPLE_WIDTH-1:0] r_in;
    logic                           r_en;
    logic        [2:0]              r_shift;
    logic signed [SAMPLE_WIDTH-1:0] r_rdata;
    logic signed [SAMPLE_WIDTH-1:0] r_out;
    logic                           r_out_valid;
    logic                           r_clearing;
    logic                           r_overrun;
    logic signed [SAMPLE_WIDTH-1:0] r_ram [DEPTH];

    // Wires
    logic        [ADDR_BITS-1:0]    w_delay;
    logic signed [SAMPLE_WIDTH-1:0] w_shifted;
    logic signed [SAMPLE_WIDTH:0]   w_sum;
    logic signed [SAMPLE_WIDTH-1:0] w_sat;
    logic                           w_ram_we;
    logic        [ADDR_BITS-1:0]    w_ram_waddr;
    logic signed [SAMPLE_WIDTH-1:0] w_ram_wdata;

    assign out_sample = r_out;
    assign out_valid  = r_out_valid;
    assign clearing   = r_clearing;
    assign overrun    = r_overrun;

    // A delay of 0 would read the slot about to be written, so it acts as 1.
    assign w_delay = (delay_samples == {ADDR_BITS{1'b0}}) ? ADDR_ONE : delay_samples;

    // Echo mix datapath: arithmetic shift keeps the sign of the delayed sample.
    always_comb begin
        w_shifted = r_rdata >>> r_shift;
        if (r_en) begin
            w_sum = {r_in[SAMPLE_WIDTH-1], r_in} + {w_shifted[SAMPLE_WIDTH-1], w_shifted};
        end else begin
            w_sum = {r_in[SAMPLE_WIDTH-1], r_in};
        end
        w_sat = saturate(w_sum);
    end

    // Single RAM write port, shared by the clear sweep and the feedback write.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_wr_ptr;
        w_ram_wdata = SAMPLE_ZERO;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_clr_addr;
                w_ram_wdata = SAMPLE_ZERO;
            end
            ST_WRITE: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_wr_ptr;
                // Disabled samples store silence so re-enabling starts clean.
                w_ram_wdata = r_en ? r_out : SAMPLE_ZERO;
            end
            default: begin
                w_ram_we    = 1'b0;
                w_ram_waddr = r_wr_ptr;
                w_ram_wdata = SAMPLE_ZERO;
            end
        endcase
    end

    // Delay-line RAM: synchronous write, synchronous read issued in READ.
    always_ff @(posedge clk_100) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
        if (r_state == ST_READ) begin
            r_rdata <= r_ram[r_rd_addr];
        end
    end

    // Control FSM, pointers, sample latches and registered outputs.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= {ADDR_BITS{1'b0}};
            r_wr_ptr    <= {ADDR_BITS{1'b0}};
            r_rd_addr   <= {ADDR_BITS{1'b0}};
            r_in        <= SAMPLE_ZERO;
            r_en        <= 1'b0;
            r_shift     <= 3'd0;
            r_out       <= SAMPLE_ZERO;
            r_out_valid <= 1'b0;
            r_clearing  <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    // Samples arriving while the RAM is being cleared pass dry.
                    if (new_sample_ready) begin
                        r_out       <= in_sample;
                        r_out_valid <= 1'b1;
                    end
                    r_clr_addr <= r_clr_addr + ADDR_ONE;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state    <= ST_IDLE;
                        r_clearing <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // Run-time controls are captured only here, once per sample.
                    if (new_sample_ready) begin
                        r_in      <= in_sample;
                        r_en      <= echo_enable;
                        r_shift   <= atten_shift;
                        r_rd_addr <= r_wr_ptr - w_delay;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (new_sample_ready) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= ST_MIX;
                end
                ST_MIX: begin
                    if (new_sample_ready) begin
                        r_overrun <= 1'b1;
                    end
                    r_out       <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (new_sample_ready) begin
                        r_overrun <= 1'b1;
                    end
                    r_wr_ptr <= r_wr_ptr + ADDR_ONE;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_delay_unit.sv
module tb_echo_delay_unit;

    localparam int SW    = 16;
    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic                 clk_100;
    logic                 reset;
    logic                 new_sample_ready;
    logic signed [SW-1:0] in_sample;
    logic                 echo_enable;
    logic [AB-1:0]        delay_samples;
    logic [2:0]           atten_shift;
    logic signed [SW-1:0] out_sample;
    logic                 out_valid;
    logic                 clearing;
    logic                 overrun;

    int n_checks;
    int n_fail;

    // Reference model: plain array delay line plus write index.
    int m_ram [DEPTH];
    int m_wr;

    echo_delay_unit #(.SAMPLE_WIDTH(SW), .ADDR_BITS(AB)) dut (
        .clk_100          (clk_100),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .in_sample        (in_sample),
        .echo_enable      (echo_enable),
        .delay_samples    (delay_samples),
        .atten_shift      (atten_shift),
        .out_sample       (out_sample),
        .out_valid        (out_valid),
        .clearing         (clearing),
        .overrun          (overrun)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;
        m_wr = 0;
    endtask

    // Expected output of one accepted sample; updates the model state.
    function automatic int model_step(input int in_v, input bit en, input int d, input int sh);
        int dd, delayed, sum;
        dd      = (d == 0) ? 1 : d;
        delayed = en ? (m_ram[(m_wr - dd + DEPTH) % DEPTH] >>> sh) : 0;
        sum     = in_v + delayed;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        m_ram[m_wr] = en ? sum : 0;
        m_wr = (m_wr + 1) % DEPTH;
        return sum;
    endfunction

    // Drive one sample, check latency, single-cycle valid and value.
    task automatic do_sample(input int in_v, input bit en, input int d, input int sh, output int obs);
        int exp_v, lat, nval;
        exp_v = model_step(in_v, en, d, sh);
        obs = 0; lat = 0; nval = 0;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b1;
        in_sample     = in_v[SW-1:0];
        echo_enable   = en;
        delay_samples = d[AB-1:0];
        atten_shift   = sh[2:0];
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_100); #1;
            if (k == 1) new_sample_ready = 1'b0;
            if (out_valid) begin
                nval++;
                if (lat == 0) begin
                    lat = k;
                    obs = int'(out_sample);
                end
            end
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL latency: got %0d edges, expected 3 (in=%0d)", lat, in_v);
        end
        n_checks++;
        if (nval !== 1) begin
            n_fail++;
            $display("FAIL valid_width: got %0d valid cycles, expected 1", nval);
        end
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sample: got %0d, expected %0d (in=%0d en=%0d d=%0d sh=%0d)",
                     obs, exp_v, in_v, en, d, sh);
        end
    endtask

    // Count edges until clearing drops; expect exactly DEPTH.
    task automatic check_clear_len(input bit pulse_in_clear);
        int k;
        k = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk_100); #1;
            if (pulse_in_clear && e == 4) begin
                new_sample_ready = 1'b0;
                n_checks++;
                if (out_valid !== 1'b1 || out_sample !== 16'sd100) begin
                    n_fail++;
                    $display("FAIL clear_passthru: valid=%0b out=%0d, expected 1/100", out_valid, out_sample);
                end
            end
            if (pulse_in_clear && e == 3) begin
                new_sample_ready = 1'b1;
                in_sample = 16'sd100;
            end
            if (clearing == 1'b0) begin
                k = e;
                break;
            end
        end
        n_checks++;
        if (k !== DEPTH) begin
            n_fail++;
            $display("FAIL clear_length: clearing dropped after %0d edges, expected %0d", k, DEPTH);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_overrun: got %0b, expected 0", overrun);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (out_sample !== 16'sd0 || out_valid !== 1'b0 || overrun !== 1'b0 || clearing !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: out=%0d valid=%0b overrun=%0b clearing=%0b, expected 0/0/0/1",
                     tag, out_sample, out_valid, overrun, clearing);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_100);
        #1;
        check_reset_values("reset_values");
        @(negedge clk_100);
        reset = 1'b0;
        model_reset();
        check_clear_len(1'b1);
    endtask

    task automatic test_impulse();
        int exp_tab [10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};
        int obs;
        for (int i = 0; i < 10; i++) begin
            do_sample((i == 0) ? 1000 : 0, 1'b1, 3, 1, obs);
            n_checks++;
            if (obs !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL impulse[%0d]: got %0d, expected %0d", i, obs, exp_tab[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int obs;
        int exp_tab [4] = '{30000, 32767, -30000, -32768};
        for (int p = 0; p < 2; p++) begin
            do_sample(0, 1'b0, 1, 0, obs);
            for (int i = 0; i < 2; i++) begin
                do_sample((p == 0) ? 30000 : -30000, 1'b1, 1, 0, obs);
                n_checks++;
                if (obs !== exp_tab[p*2+i]) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got %0d, expected %0d", p*2+i, obs, exp_tab[p*2+i]);
                end
            end
        end
    endtask

    task automatic test_disable();
        int obs, in_v;
        for (int i = 0; i < DEPTH; i++) begin
            in_v = int'($urandom_range(0, 65535)) - 32768;
            do_sample(in_v, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), obs);
            n_checks++;
            if (obs !== in_v) begin
                n_fail++;
                $display("FAIL dry_pass: got %0d, expected %0d", obs, in_v);
            end
        end
        for (int i = 0; i < DEPTH + 4; i++) begin
            do_sample(0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), obs);
            n_checks++;
            if (obs !== 0) begin
                n_fail++;
                $display("FAIL reenable_clean: got %0d, expected 0", obs);
            end
        end
    endtask

    task automatic test_random();
        int obs;
        for (int i = 0; i < 40; i++) begin
            do_sample(int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), obs);
        end
    endtask

    task automatic test_wrap_clamp();
        int obs;
        for (int i = 0; i < DEPTH; i++) do_sample(0, 1'b0, 1, 0, obs);
        do_sample(4000, 1'b1, 15, 2, obs);
        for (int i = 1; i <= 15; i++) begin
            do_sample(0, 1'b1, 15, 2, obs);
            n_checks++;
            if (obs !== ((i == 15) ? 1000 : 0)) begin
                n_fail++;
                $display("FAIL wrap_d15[%0d]: got %0d, expected %0d", i, obs, (i == 15) ? 1000 : 0);
            end
        end
        for (int i = 0; i < DEPTH; i++) do_sample(0, 1'b0, 1, 0, obs);
        do_sample(800, 1'b1, 0, 1, obs);
        do_sample(0, 1'b1, 0, 1, obs);
        n_checks++;
        if (obs !== 400) begin
            n_fail++;
            $display("FAIL clamp_d0: got %0d, expected 400", obs);
        end
    endtask

    task automatic test_overrun();
        int exp_v, obs;
        exp_v = model_step(1234, 1'b0, 1, 0);
        @(posedge clk_100); #1;
        new_sample_ready = 1'b1; in_sample = 16'sd1234; echo_enable = 1'b0;
        delay_samples = 4'd1; atten_shift = 3'd0;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b0;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b1; in_sample = 16'sd12345;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || int'(out_sample) !== exp_v) begin
            n_fail++;
            $display("FAIL overrun_first: valid=%0b out=%0d, expected 1/%0d", out_valid, out_sample, exp_v);
        end
        @(posedge clk_100); #1;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %0b, expected 1", overrun);
        end
        do_sample(-777, 1'b1, 2, 1, obs);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %0b, expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid_mix();
        int obs;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b1; in_sample = 16'sd5000; echo_enable = 1'b1;
        @(posedge clk_100); #1;
        new_sample_ready = 1'b0;
        @(posedge clk_100); #1;
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid_mix");
        @(negedge clk_100);
        reset = 1'b0;
        model_reset();
        check_clear_len(1'b0);
        do_sample(300, 1'b1, 1, 0, obs);
        do_sample(0, 1'b1, 1, 0, obs);
        n_checks++;
        if (obs !== 300) begin
            n_fail++;
            $display("FAIL after_reset_echo: got %0d, expected 300", obs);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        new_sample_ready = 1'b0;
        in_sample     = 16'sd0;
        echo_enable   = 1'b0;
        delay_samples = 4'd1;
        atten_shift   = 3'd0;
        model_reset();
        test_reset();
        test_impulse();
        test_saturation();
        test_disable();
        test_random();
        test_wrap_clamp();
        test_overrun();
        test_reset_mid_mix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
